// File: rtl/exp_align_stage.sv
// Purpose : exponent-align front end of an FP32 adder; orders the operand pair by
//           magnitude and produces mantissas, right-shift amount and special flags.
// Latency : 2 cycles (S1 unpack/compare, S2 swap/shift), 1 pair per cycle sustained.
// Backpressure: valid/ready; S2 holds while out_ready is low, S1 moves into S2 as soon
//           as S2 frees, in_ready = !s1_valid || S2 advances.
// Ports   : clk, reset (sync, active-high); in_valid/in_ready/a/b upstream;
//           out_valid/out_ready, big_mant, small_mant, shift, exp_out,
//           sign_big, sign_small, is_nan, is_inf, is_zero downstream.
module exp_align_stage #(
    parameter int WIDTH = 26,
    parameter int SHW   = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      a,
    input  logic [31:0]      b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] big_mant,
    output logic [WIDTH-1:0] small_mant,
    output logic [SHW-1:0]   shift,
    output logic [7:0]       exp_out,
    output logic             sign_big,
    output logic             sign_small,
    output logic             is_nan,
    output logic             is_inf,
    output logic             is_zero
);

    localparam logic [8:0] SAT = 9'(WIDTH);

    // ---------------- pipeline control ----------------
    logic s1_valid;
    logic s2_valid;
    logic s2_adv;
    logic s1_adv;

    assign s2_adv    = !s2_valid || out_ready;
    assign s1_adv    = !s1_valid || s2_adv;
    assign in_ready  = s1_adv;
    assign out_valid = s2_valid;

    // ---------------- S1: unpack and compare ----------------
    logic [7:0]  ea_raw, eb_raw;
    logic [22:0] fa, fb;
    logic        ha, hb;
    logic [7:0]  ea_eff, eb_eff;
    logic        a_nan, b_nan, a_inf, b_inf;
    logic        nan_c, inf_c, zero_c, a_big_c;
    logic [8:0]  diff_c;

    assign ea_raw = a[30:23];
    assign eb_raw = b[30:23];
    assign fa     = a[22:0];
    assign fb     = b[22:0];
    // Denormals and zero share the exponent of the smallest normal.
    assign ha     = |ea_raw;
    assign hb     = |eb_raw;
    assign ea_eff = ha ? ea_raw : 8'd1;
    assign eb_eff = hb ? eb_raw : 8'd1;
    assign diff_c = {1'b0, ea_eff} - {1'b0, eb_eff};
    // Ties keep a as the big operand.
    assign a_big_c = (ea_eff > eb_eff) || ((ea_eff == eb_eff) && (fa >= fb));

    assign a_nan  = (ea_raw == 8'hFF) && (fa != 23'd0);
    assign b_nan  = (eb_raw == 8'hFF) && (fb != 23'd0);
    assign a_inf  = (ea_raw == 8'hFF) && (fa == 23'd0);
    assign b_inf  = (eb_raw == 8'hFF) && (fb == 23'd0);
    assign nan_c  = a_nan || b_nan || (a_inf && b_inf && (a[31] != b[31]));
    assign inf_c  = (a_inf || b_inf) && !nan_c;
    assign zero_c = (a[30:0] == 31'd0) && (b[30:0] == 31'd0);

    logic        s1_sa, s1_sb, s1_ha, s1_hb;
    logic [22:0] s1_fa, s1_fb;
    logic [7:0]  s1_ea, s1_eb;
    logic [8:0]  s1_diff;
    logic        s1_a_big, s1_nan, s1_inf, s1_zero;

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid <= 1'b0;
            s1_sa    <= 1'b0;
            s1_sb    <= 1'b0;
            s1_ha    <= 1'b0;
            s1_hb    <= 1'b0;
            s1_fa    <= '0;
            s1_fb    <= '0;
            s1_ea    <= '0;
            s1_eb    <= '0;
            s1_diff  <= '0;
            s1_a_big <= 1'b0;
            s1_nan   <= 1'b0;
            s1_inf   <= 1'b0;
            s1_zero  <= 1'b0;
        end else if (s1_adv) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_sa    <= a[31];
                s1_sb    <= b[31];
                s1_ha    <= ha;
                s1_hb    <= hb;
                s1_fa    <= fa;
                s1_fb    <= fb;
                s1_ea    <= ea_eff;
                s1_eb    <= eb_eff;
                s1_diff  <= diff_c;
                s1_a_big <= a_big_c;
                s1_nan   <= nan_c;
                s1_inf   <= inf_c;
                s1_zero  <= zero_c;
            end
        end
    end

    // ---------------- S2: swap and shift amount ----------------
    logic [WIDTH-1:0] mant_a, mant_b;
    logic [8:0]       mag_c, sat_c;

    assign mant_a = {1'b0, s1_ha, s1_fa, {(WIDTH-25){1'b0}}};
    assign mant_b = {1'b0, s1_hb, s1_fb, {(WIDTH-25){1'b0}}};
    assign mag_c  = s1_diff[8] ? (9'd0 - s1_diff) : s1_diff;
    // Beyond WIDTH positions the shifter already yields zero.
    assign sat_c  = (mag_c > SAT) ? SAT : mag_c;

    always_ff @(posedge clk) begin
        if (reset) begin
            s2_valid   <= 1'b0;
            big_mant   <= '0;
            small_mant <= '0;
            shift      <= '0;
            exp_out    <= '0;
            sign_big   <= 1'b0;
            sign_small <= 1'b0;
            is_nan     <= 1'b0;
            is_inf     <= 1'b0;
            is_zero    <= 1'b0;
        end else if (s2_adv) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                big_mant   <= s1_a_big ? mant_a : mant_b;
                small_mant <= s1_a_big ? mant_b : mant_a;
                exp_out    <= s1_a_big ? s1_ea : s1_eb;
                sign_big   <= s1_a_big ? s1_sa : s1_sb;
                sign_small <= s1_a_big ? s1_sb : s1_sa;
                shift      <= SHW'(sat_c);
                is_nan     <= s1_nan;
                is_inf     <= s1_inf;
                is_zero    <= s1_zero;
            end
        end
    end

endmodule
